// File: rtl/cga_pkg.sv
// Shared CGA definitions: VRAM geometry, frame-buffer window and arbiter states.
package cga_pkg;

    // Video RAM address width (512K words).
    localparam int unsigned VRAM_AW = 19;

    // bus_a[19:15] value that selects the B8000-BFFFF frame-buffer window.
    localparam logic [4:0] FB_BASE_DEFAULT = 5'h17;

    // CPU access sequencing in the VRAM arbiter.
    typedef enum logic [2:0] {
        StIdle,
        StPend,
        StAcc,
        StRdat,
        StHold
    } arb_state_e;

endpackage

// File: rtl/cga_vram_arbiter.sv
// Shares the synchronous VRAM between display fetches and buffered CPU cycles.
// Display reads pass straight through; CPU accesses wait in a one-deep request
// register for a sequencer slot while bus_rdy holds the ISA bus.
module cga_vram_arbiter
    import cga_pkg::*;
#(
    parameter int unsigned USE_BUS_WAIT = 1,
    parameter logic [4:0]  FB_BASE      = FB_BASE_DEFAULT
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [19:0]        bus_a,
    input  logic               bus_memr_l,
    input  logic               bus_memw_l,
    input  logic [7:0]         bus_d,
    output logic [7:0]         bus_out_mem,
    output logic               bus_mem_dir,
    output logic               bus_rdy,
    input  logic               disp_read,
    input  logic [VRAM_AW-1:0] disp_addr,
    output logic [7:0]         disp_data,
    input  logic               isa_op_enable,
    output logic               ram_en,
    output logic               ram_we,
    output logic [VRAM_AW-1:0] ram_addr,
    output logic [7:0]         ram_dout,
    input  logic [7:0]         ram_din,
    output logic [7:0]         cpu_wait_max
);

    arb_state_e         state_q;
    logic [VRAM_AW-1:0] req_addr_q;
    logic [7:0]         req_data_q;
    logic               req_we_q;
    logic [7:0]         rd_latch_q;
    logic [7:0]         wait_cnt_q;
    logic [7:0]         wait_max_q;
    logic               rdy_q;

    logic mem_cs;
    logic cpu_sel;
    logic req_strobe;

    assign mem_cs  = (bus_a[19:15] == FB_BASE);
    assign cpu_sel = mem_cs & (~bus_memr_l | ~bus_memw_l);
    // Only the strobe matching the latched request keeps it alive in PEND.
    assign req_strobe = req_we_q ? ~bus_memw_l : ~bus_memr_l;

    // CPU request FSM with registered request, read latch, ready and wait statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            req_addr_q <= '0;
            req_data_q <= '0;
            req_we_q   <= 1'b0;
            rd_latch_q <= '0;
            wait_cnt_q <= '0;
            wait_max_q <= '0;
            rdy_q      <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cpu_sel) begin
                        req_addr_q <= {4'h0, bus_a[14:0]};
                        req_data_q <= bus_d;
                        req_we_q   <= ~bus_memw_l;
                        wait_cnt_q <= '0;
                        rdy_q      <= 1'b0;
                        state_q    <= StPend;
                    end
                end
                StPend: begin
                    if (!req_strobe) begin
                        // CPU gave up before a slot arrived: drop the access.
                        rdy_q   <= 1'b1;
                        state_q <= StIdle;
                    end else if (isa_op_enable && !disp_read) begin
                        if (wait_cnt_q > wait_max_q) begin
                            wait_max_q <= wait_cnt_q;
                        end
                        state_q <= StAcc;
                    end else if (wait_cnt_q != 8'hFF) begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                StAcc: begin
                    rdy_q   <= req_we_q;
                    state_q <= req_we_q ? StHold : StRdat;
                end
                StRdat: begin
                    rd_latch_q <= ram_din;
                    rdy_q      <= 1'b1;
                    state_q    <= StHold;
                end
                StHold: begin
                    if ((bus_memr_l && bus_memw_l) || !mem_cs) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    rdy_q   <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // RAM port mux: display fetch has absolute priority over the CPU slot.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_dout = '0;
        if (disp_read) begin
            ram_en   = 1'b1;
            ram_addr = disp_addr;
        end else if (state_q == StAcc) begin
            ram_en   = 1'b1;
            ram_we   = req_we_q;
            ram_addr = req_addr_q;
            ram_dout = req_data_q;
        end
    end

    assign disp_data    = ram_din;
    assign bus_out_mem  = (state_q == StHold && !req_we_q) ? rd_latch_q : 8'h00;
    assign bus_mem_dir  = mem_cs & ~bus_memr_l;
    assign cpu_wait_max = wait_max_q;
    // Pull ready low in the same cycle the strobe appears, before the FSM registers it.
    assign bus_rdy = (USE_BUS_WAIT != 0) ? (rdy_q & ~((state_q == StIdle) & cpu_sel)) : 1'b1;

endmodule

// File: tb/tb_cga_vram_arbiter.sv
// Scoreboard bench for cga_vram_arbiter: directed CPU/display scenarios push
// expected RAM writes and CPU read data; negedge monitors pop and compare.
module tb_cga_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [19:0] bus_a;
    logic        bus_memr_l;
    logic        bus_memw_l;
    logic [7:0]  bus_d;
    logic [7:0]  bus_out_mem;
    logic        bus_mem_dir;
    logic        bus_rdy;
    logic        disp_read;
    logic [18:0] disp_addr;
    logic [7:0]  disp_data;
    logic        isa_op_enable;
    logic        ram_en;
    logic        ram_we;
    logic [18:0] ram_addr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din = 8'h00;
    logic [7:0]  cpu_wait_max;

    int errors = 0;
    int checks = 0;

    logic [26:0] exp_wr[$];   // {addr, data}
    logic [7:0]  exp_rd[$];

    logic [7:0]  mem [0:255];
    logic        ovr_en = 1'b0;
    logic [7:0]  ovr_val = 8'h00;
    logic        rdy_prev = 1'b1;
    int          low;

    always #5 clk = ~clk;

    cga_vram_arbiter dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus_a         (bus_a),
        .bus_memr_l    (bus_memr_l),
        .bus_memw_l    (bus_memw_l),
        .bus_d         (bus_d),
        .bus_out_mem   (bus_out_mem),
        .bus_mem_dir   (bus_mem_dir),
        .bus_rdy       (bus_rdy),
        .disp_read     (disp_read),
        .disp_addr     (disp_addr),
        .disp_data     (disp_data),
        .isa_op_enable (isa_op_enable),
        .ram_en        (ram_en),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_dout      (ram_dout),
        .ram_din       (ram_din),
        .cpu_wait_max  (cpu_wait_max)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Synchronous RAM model: address at edge N, data during cycle N+1.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr[7:0]] <= ram_dout;
            else        ram_din <= ovr_en ? ovr_val : mem[ram_addr[7:0]];
        end
    end

    // Write monitor: every RAM write cycle must match the next expected write.
    always @(negedge clk) begin
        if (ram_en && ram_we) begin
            if (exp_wr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                         ram_addr, ram_dout);
            end else begin
                chk("ram_write", {5'b0, ram_addr, ram_dout}, {5'b0, exp_wr.pop_front()});
            end
        end
    end

    // Read monitor: when ready returns with a read outstanding, data must be valid.
    always @(negedge clk) begin
        if (bus_rdy && !rdy_prev && exp_rd.size() != 0) begin
            chk("cpu_read_data", {24'h0, bus_out_mem}, {24'h0, exp_rd.pop_front()});
        end
        rdy_prev <= bus_rdy;
    end

    task automatic cpu_access(input string tag, input logic [19:0] a, input logic we,
                              input logic [7:0] d, input int disp_cycles, output int lowc);
        bit done;
        bit dir_ok;
        bit disp_ok;
        done = 1'b0;
        dir_ok = 1'b1;
        disp_ok = 1'b1;
        lowc = 0;
        @(negedge clk);
        bus_a = a;
        bus_d = d;
        if (we) bus_memw_l = 1'b0;
        else    bus_memr_l = 1'b0;
        #1;
        chk({tag, "_rdy_comb"}, {31'h0, bus_rdy}, 32'h0);
        @(posedge clk);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i < disp_cycles) begin
                disp_read = 1'b1;
                disp_addr = 19'h40000 + 19'(i * 3);
                #1;
                if (!(ram_en && !ram_we && ram_addr == disp_addr && disp_data == ram_din))
                    disp_ok = 1'b0;
            end else begin
                disp_read = 1'b0;
            end
            if (!we && !bus_mem_dir) dir_ok = 1'b0;
            if (bus_rdy) begin
                done = 1'b1;
                break;
            end
            lowc++;
        end
        chk({tag, "_rdy_returned"}, {31'h0, done}, 32'h1);
        if (!we) chk({tag, "_mem_dir"}, {31'h0, dir_ok}, 32'h1);
        if (disp_cycles > 0) chk({tag, "_disp_priority"}, {31'h0, disp_ok}, 32'h1);
        bus_memw_l = 1'b1;
        bus_memr_l = 1'b1;
        @(negedge clk);
        chk({tag, "_idle_rdy"}, {31'h0, bus_rdy}, 32'h1);
        chk({tag, "_idle_out"}, {24'h0, bus_out_mem}, 32'h0);
    endtask

    initial begin
        bit ok;
        reset_n = 1'b0;
        bus_a = 20'h00000;
        bus_memr_l = 1'b1;
        bus_memw_l = 1'b1;
        bus_d = 8'h00;
        disp_read = 1'b0;
        disp_addr = '0;
        isa_op_enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_rdy", {31'h0, bus_rdy}, 32'h1);
        chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
        chk("rst_ram_we", {31'h0, ram_we}, 32'h0);
        chk("rst_out_mem", {24'h0, bus_out_mem}, 32'h0);
        chk("rst_wait_max", {24'h0, cpu_wait_max}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Best-case write: two registered wait states (PEND, ACC).
        exp_wr.push_back({19'h00010, 8'hA5});
        cpu_access("wr", 20'hB8010, 1'b1, 8'hA5, 0, low);
        chk("wr_wait_states", low, 32'd2);
        chk("wr_wait_max", {24'h0, cpu_wait_max}, 32'h0);

        // Best-case read: three wait states (PEND, ACC, RDAT).
        ovr_en = 1'b1;
        ovr_val = 8'h3C;
        exp_rd.push_back(8'h3C);
        cpu_access("rd", 20'hB8010, 1'b0, 8'h00, 0, low);
        chk("rd_wait_states", low, 32'd3);
        ovr_en = 1'b0;

        // Display holds the RAM for 20 PEND cycles; write lands once it lets go.
        exp_wr.push_back({19'h00040, 8'h77});
        cpu_access("dispwr", 20'hB8040, 1'b1, 8'h77, 20, low);
        chk("dispwr_wait_states", low, 32'd22);
        chk("dispwr_wait_max", {24'h0, cpu_wait_max}, 32'd20);

        // Read back what the CPU wrote through the model RAM.
        exp_rd.push_back(8'h77);
        cpu_access("rdback", 20'hB8040, 1'b0, 8'h00, 0, low);
        chk("rdback_wait_states", low, 32'd3);

        // Outside the window: arbiter ignores the cycle.
        @(negedge clk);
        bus_a = 20'hA0010;
        bus_d = 8'h99;
        bus_memw_l = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (!bus_rdy || ram_en || bus_mem_dir) ok = 1'b0;
            @(negedge clk);
        end
        chk("offwin_ignored", {31'h0, ok}, 32'h1);
        bus_memw_l = 1'b1;
        @(negedge clk);

        // Strobe dropped in PEND: access discarded, no RAM write.
        isa_op_enable = 1'b0;
        bus_a = 20'hB8060;
        bus_d = 8'h55;
        bus_memw_l = 1'b0;
        #1;
        chk("drop_rdy_comb", {31'h0, bus_rdy}, 32'h0);
        @(negedge clk);
        chk("drop_rdy_pend", {31'h0, bus_rdy}, 32'h0);
        @(negedge clk);
        bus_memw_l = 1'b1;
        @(negedge clk);
        chk("drop_rdy_idle", {31'h0, bus_rdy}, 32'h1);
        isa_op_enable = 1'b1;
        repeat (3) @(negedge clk);
        chk("drop_wait_max", {24'h0, cpu_wait_max}, 32'd20);

        // Reset during the ACC cycle of a write suppresses the write at once.
        bus_a = 20'hB8030;
        bus_d = 8'hEE;
        bus_memw_l = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("acc_we_before_rst", {31'h0, ram_we}, 32'h1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_we_async", {31'h0, ram_we}, 32'h0);
        chk("rst_en_async", {31'h0, ram_en}, 32'h0);
        @(negedge clk);
        bus_memw_l = 1'b1;
        #1;
        chk("rst_mid_rdy", {31'h0, bus_rdy}, 32'h1);
        chk("rst_mid_wait_max", {24'h0, cpu_wait_max}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_rdy", {31'h0, bus_rdy}, 32'h1);

        // Normal operation resumes after reset.
        exp_wr.push_back({19'h00030, 8'hC3});
        cpu_access("postwr", 20'hB8030, 1'b1, 8'hC3, 0, low);
        chk("postwr_wait_states", low, 32'd2);

        repeat (3) @(negedge clk);
        chk("writes_all_seen", exp_wr.size(), 32'h0);
        chk("reads_all_seen", exp_rd.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

endmodule
